// File: rtl/rd53_bgpv_hit_tot_digitizer.sv
// Per-pixel HIT synchroniser and time-over-threshold digitizer with a
// single-entry valid/ready event buffer and saturating lost-hit counter.
module rd53_bgpv_hit_tot_digitizer #(
  parameter int TOT_BITS    = 4,
  parameter int TS_BITS     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK_BX,
  input  logic               RESET,
  input  logic               HIT,
  input  logic               ENABLE,
  input  logic               POWER_DOWN,
  input  logic [TS_BITS-1:0] BCID,
  output logic               EVT_VALID,
  input  logic               EVT_READY,
  output logic [TOT_BITS-1:0] EVT_TOT,
  output logic [TS_BITS-1:0] EVT_BCID,
  output logic               BUSY,
  output logic [7:0]         LOST_CNT
);

  // All-ones ToT is reserved as "no hit", so the counter stops one below it.
  localparam logic [TOT_BITS-1:0] TOT_MAX = TOT_BITS'((1 << TOT_BITS) - 2);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t               state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 hit_s, hit_s_d, rise, start;
  logic                 emit, load, drop;
  logic [TOT_BITS-1:0]  tot;
  logic [TS_BITS-1:0]   bcid_lat;

  assign hit_s = sync_q[SYNC_STAGES-1];
  assign rise  = hit_s & ~hit_s_d;
  assign start = rise & ENABLE & ~POWER_DOWN;

  always_ff @(posedge CLK_BX or posedge RESET) begin
    if (RESET) begin
      sync_q  <= '0;
      hit_s_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], HIT};
      hit_s_d <= hit_s;
    end
  end

  always_ff @(posedge CLK_BX or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COUNT;
      COUNT:   if (POWER_DOWN || !hit_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Power-down wins over a coincident falling edge: no emit on abort.
  always_comb begin
    BUSY = 1'b0;
    emit = 1'b0;
    if (state == COUNT) begin
      BUSY = 1'b1;
      emit = !POWER_DOWN && !hit_s;
    end
  end

  assign load = emit & (~EVT_VALID | EVT_READY);
  assign drop = emit & ~load;

  always_ff @(posedge CLK_BX or posedge RESET) begin
    if (RESET) begin
      tot      <= '0;
      bcid_lat <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        tot      <= TOT_BITS'(1);
        bcid_lat <= BCID;
      end
    end else if (hit_s && tot != TOT_MAX) begin
      tot <= tot + TOT_BITS'(1);
    end
  end

  // Event buffer: a drain and a load in the same cycle keeps EVT_VALID high.
  always_ff @(posedge CLK_BX or posedge RESET) begin
    if (RESET) begin
      EVT_VALID <= 1'b0;
      EVT_TOT   <= '0;
      EVT_BCID  <= '0;
    end else if (load) begin
      EVT_VALID <= 1'b1;
      EVT_TOT   <= tot;
      EVT_BCID  <= bcid_lat;
    end else if (EVT_VALID && EVT_READY) begin
      EVT_VALID <= 1'b0;
    end
  end

  always_ff @(posedge CLK_BX or posedge RESET) begin
    if (RESET)                         LOST_CNT <= '0;
    else if (drop && LOST_CNT != 8'hFF) LOST_CNT <= LOST_CNT + 8'd1;
  end

endmodule
